// File: rtl/dpram_port_arbiter_if.sv
// Bundle joining two RAM requesters and the single shared RAM port.
// The arbiter takes the slave side; requesters and RAM model take master.
interface dpram_port_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [8:0]  m0_addr;
  logic [1:0]  m0_sel;
  logic [15:0] m0_wdata;
  logic        m0_lock;
  logic        m0_ack;
  logic [15:0] m0_rdata;
  logic        m0_rvalid;
  logic        m1_req;
  logic        m1_we;
  logic [8:0]  m1_addr;
  logic [1:0]  m1_sel;
  logic [15:0] m1_wdata;
  logic        m1_lock;
  logic        m1_ack;
  logic [15:0] m1_rdata;
  logic        m1_rvalid;
  logic        ram_ce;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [1:0]  ram_sel;
  logic [15:0] ram_write;
  logic [15:0] ram_read;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
    output m0_ack, m0_rdata, m0_rvalid,
    output m1_ack, m1_rdata, m1_rvalid,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_write,
    input  ram_read
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
    input  m0_ack, m0_rdata, m0_rvalid,
    input  m1_ack, m1_rdata, m1_rvalid,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_write,
    output ram_read
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Two-requester round-robin arbiter with lock, driving one synchronous
// RAM port; reads return three cycles after the grant edge.
module dpram_port_arbiter (
  input logic               clk,
  input logic               reset,
  dpram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt0, gnt1, gnt, gwe;
  logic        ce_q, ce_d, we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wr_q, wr_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        rd1_v_q, rd1_v_d, rd1_o_q, rd1_o_d;
  logic        rd2_v_q, rd2_v_d, rd2_o_q, rd2_o_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // last_q=1 means m1 won most recently, so m0 wins the next tie
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      LOCK0: begin
        if (bus.m0_req) gnt0 = 1'b1;
        else            state_d = IDLE;
      end
      LOCK1: begin
        if (bus.m1_req) gnt1 = 1'b1;
        else            state_d = IDLE;
      end
      default: begin
        if (bus.m0_req && bus.m1_req) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = bus.m0_req;
          gnt1 = bus.m1_req;
        end
      end
    endcase
    if (gnt0) begin
      last_d  = 1'b0;
      state_d = bus.m0_lock ? LOCK0 : IDLE;
    end
    if (gnt1) begin
      last_d  = 1'b1;
      state_d = bus.m1_lock ? LOCK1 : IDLE;
    end
  end

  always_comb begin
    gnt      = gnt0 | gnt1;
    gwe      = gnt0 ? bus.m0_we : bus.m1_we;
    ce_d     = gnt;
    we_d     = gnt & gwe;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    if (gnt0) begin
      addr_d = bus.m0_addr;
      sel_d  = bus.m0_sel;
      wr_d   = bus.m0_wdata;
    end else if (gnt1) begin
      addr_d = bus.m1_addr;
      sel_d  = bus.m1_sel;
      wr_d   = bus.m1_wdata;
    end
    ack0_d   = gnt0;
    ack1_d   = gnt1;
    rd1_v_d  = gnt & !gwe;
    rd1_o_d  = gnt1;
    rd2_v_d  = rd1_v_q;
    rd2_o_d  = rd1_o_q;
    rv0_d    = rd2_v_q & !rd2_o_q;
    rv1_d    = rd2_v_q & rd2_o_q;
    rdata0_d = rv0_d ? bus.ram_read : rdata0_q;
    rdata1_d = rv1_d ? bus.ram_read : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wr_q     <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd1_v_q  <= 1'b0;
      rd1_o_q  <= 1'b0;
      rd2_v_q  <= 1'b0;
      rd2_o_q  <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd1_v_q  <= rd1_v_d;
      rd1_o_q  <= rd1_o_d;
      rd2_v_q  <= rd2_v_d;
      rd2_o_q  <= rd2_o_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.ram_ce    = ce_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_sel   = sel_q;
  assign bus.ram_write = wr_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_rvalid = rv0_q;
  assign bus.m1_rvalid = rv1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
endmodule
